fifo_word_packer: RTL and testbench

//  Downstream drain stage for the 16x8 synchronous byte FIFO. Pops bytes via the

---
 rtl/fifo_word_packer.sv | 80 ++++++++
 tb/tb_fifo_word_packer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// Drain stage for a synchronous byte FIFO. It packs WORD_BYTES consecutive bytes into one
// little-endian word and presents it on a valid/ready output; flush emits a partial word.
module fifo_word_packer #(
    parameter int BYTE_W     = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    input  logic [BYTE_W-1:0]            fifo_data,
    output logic                         fifo_rd,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BYTE_W*WORD_BYTES-1:0] out_data,
    output logic [3:0]                   out_nbytes
);

    localparam int                WORD_W   = BYTE_W * WORD_BYTES;
    localparam int                CNT_W    = 4;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(WORD_BYTES);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_land;
    logic              rd_pend;
    logic              asm_full;
    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] asm_land;
    logic              out_free;
    logic              emit;

    // The *_land signals describe the assembly after this edge's in-flight byte
    // lands, so a word can complete and transfer on the same edge.
    always_comb begin
        // NOTE: every signal gets a default first so no latch can be inferred.
        asm_land = asm_q;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (rd_pend && cnt == CNT_W'(i)) begin
                asm_land[i*BYTE_W +: BYTE_W] = fifo_data;
            end
        end
        cnt_land = cnt + CNT_W'(rd_pend);
        out_free = !out_valid || out_ready;
        // A held word keeps requesting until the output register frees up.
        emit     = (cnt_land == FULL_CNT) || ((flush || asm_full) && cnt_land != '0);
        fifo_rd  = !rst && !fifo_empty && !asm_full && (cnt_land < FULL_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the assembly register is reset too, because lanes above cnt must read 0.
            cnt        <= '0;
            rd_pend    <= 1'b0;
            asm_full   <= 1'b0;
            asm_q      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_nbytes <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
            rd_pend <= fifo_rd;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (emit && out_free) begin
                out_valid  <= 1'b1;
                out_data   <= asm_land;
                out_nbytes <= cnt_land;
                cnt        <= '0;
                asm_q      <= '0;
                asm_full   <= 1'b0;
            end else begin
                cnt      <= cnt_land;
                asm_q    <= asm_land;
                asm_full <= emit;
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Randomised and directed bench for fifo_word_packer. A queue-based FIFO model feeds the DUT,
// a byte-grouping reference model predicts words, and a monitor scores every accepted word.
module tb_fifo_word_packer;

    localparam int WB = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  nbytes;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_rd;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_nbytes;

    fifo_word_packer #(.BYTE_W(8), .WORD_BYTES(WB)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_nbytes (out_nbytes)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    logic [7:0] model_bytes[$];
    word_t      exp_q[$];

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int rd_count = 0;
    int rd4_edge = 0;
    int first_valid_edge = -1;
    logic force_empty = 1'b0;
    logic toggle_mode = 1'b0;
    logic rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: bytes are grouped in arrival order, little-endian, WB per word.
    task automatic emit_model();
        word_t w;
        w.data   = '0;
        w.nbytes = 4'(model_bytes.size());
        for (int i = 0; i < model_bytes.size(); i++) begin
            w.data = w.data | (32'(model_bytes[i]) << (8 * i));
        end
        exp_q.push_back(w);
        model_bytes.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        model_bytes.push_back(b);
        if (model_bytes.size() == WB) emit_model();
    endtask

    task automatic flush_model();
        if (model_bytes.size() != 0) emit_model();
    endtask

    task automatic refresh_empty();
        fifo_empty = (fifo_q.size() == 0) || force_empty;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words still expected after %0d cycles", exp_q.size(), bound);
        end
        step();
    endtask

    // FIFO model: data appears the cycle after the read strobe.
    always @(posedge clk) begin : fifo_model
        logic took;
        took = fifo_rd;
        edge_n++;
        #1;
        if (took) begin
            checks++;
            if (fifo_q.size() == 0) begin
                errors++;
                $display("FAIL read_while_empty: got fifo_rd=1 expected 0 at edge %0d", edge_n);
            end else begin
                fifo_data = fifo_q.pop_front();
            end
            rd_count++;
            if (rd_count == WB) rd4_edge = edge_n;
        end
        if (toggle_mode) force_empty = ~force_empty;
        fifo_empty = (fifo_q.size() == 0) || force_empty;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin : monitor
        word_t e;
        if (!rst && out_valid) begin
            if (first_valid_edge < 0) first_valid_edge = edge_n;
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h/%0d expected no word", out_data, out_nbytes);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", 64'(out_data), 64'(e.data));
                    check("word_nbytes", 64'(out_nbytes), 64'(e.nbytes));
                end
            end
        end
    end

    initial begin
        int n;
        repeat (2) step();
        check("reset_fifo_rd", 64'(fifo_rd), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_nbytes", 64'(out_nbytes), 64'd0);
        rst = 1'b0;
        step();

        // Preloaded FIFO, sink always ready; also measures read-to-valid latency.
        out_ready = 1'b1;
        rd_count = 0;
        first_valid_edge = -1;
        for (int b = 8'h11; b <= 8'h18; b++) push_byte(8'(b));
        refresh_empty();
        wait_drain(100);
        check("latency_edges", 64'(first_valid_edge), 64'(rd4_edge + 1));

        // Blocked sink: one word in the output register, one in assembly, 4 bytes left.
        out_ready = 1'b0;
        for (int b = 8'h21; b <= 8'h2C; b++) push_byte(8'(b));
        refresh_empty();
        repeat (20) step();
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_out_data", 64'(out_data), 64'h24232221);
        check("stall_fifo_rd", 64'(fifo_rd), 64'd0);
        check("stall_fifo_left", 64'(fifo_q.size()), 64'd4);
        out_ready = 1'b1;
        wait_drain(100);

        // Partial word via flush, then a flush with nothing assembled.
        push_byte(8'hAA);
        push_byte(8'hBB);
        refresh_empty();
        repeat (6) step();
        flush_model();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_drain(50);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (5) step();
        check("idle_flush_no_word", 64'(out_valid), 64'd0);

        // Flush while the third byte is still in flight.
        rd_count = 0;
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        refresh_empty();
        n = 0;
        while (rd_count < 3 && n < 50) begin
            step();
            n++;
        end
        check("inflight_reads", 64'(rd_count), 64'd3);
        flush_model();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_drain(50);

        // Random stream with a toggling empty flag and random sink backpressure.
        toggle_mode = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) push_byte(8'($urandom_range(0, 255)));
        refresh_empty();
        wait_drain(20000);
        toggle_mode = 1'b0;
        rand_ready = 1'b0;
        force_empty = 1'b0;
        out_ready = 1'b1;
        refresh_empty();
        step();

        // Asynchronous reset with a word in the output register and two bytes assembled.
        out_ready = 1'b0;
        for (int b = 8'h41; b <= 8'h46; b++) push_byte(8'(b));
        refresh_empty();
        repeat (15) step();
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_out_data", 64'(out_data), 64'd0);
        check("async_out_nbytes", 64'(out_nbytes), 64'd0);
        check("async_fifo_rd", 64'(fifo_rd), 64'd0);
        exp_q.delete();
        model_bytes.delete();
        repeat (2) step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int b = 8'h51; b <= 8'h54; b++) push_byte(8'(b));
        refresh_empty();
        wait_drain(50);

        repeat (5) step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
